// File: rtl/bcd_eo_scheduler.sv
// bcd_eo_scheduler
// ----------------
// Sequencer and arbiter for a shared 4-bit even/odd BCD counter.
// Two clients (even, odd) request the counter.  The block grants one at a
// time with round-robin fairness.  It presets the count with an MR (to 0)
// or MS (to 9) strobe pair, then steps the count by 2 (mod 10) for the
// burst length latched at grant, and finally pulses done.
//
// Ports
//   Clk                 rising-edge clock
//   rst                 synchronous active-high reset
//   req_even, req_odd   level requests, held until done or abort
//   len_even, len_odd   burst lengths in steps, sampled at grant
//   gnt_even, gnt_odd   ownership of the counter (never both high)
//   done                one-cycle pulse at burst completion
//   MS1, MS2            set-to-9 strobes (odd preset)
//   MR1, MR2            reset-to-0 strobes (even preset)
//   Q, Qbar             shared BCD count (0..9) and its complement
//   pause               only with BCD_SCHED_PAUSE_EN: freezes stepping in RUN
//
// Configuration macro: BCD_SCHED_PAUSE_EN (adds the pause input).

module bcd_eo_scheduler #(
   parameter int BURST_W = 4
) (
   input  logic               Clk,
   input  logic               rst,
   input  logic               req_even,
   input  logic               req_odd,
   input  logic [BURST_W-1:0] len_even,
   input  logic [BURST_W-1:0] len_odd,
`ifdef BCD_SCHED_PAUSE_EN
   input  logic               pause,
`endif
   output logic               gnt_even,
   output logic               gnt_odd,
   output logic               done,
   output logic               MS1,
   output logic               MS2,
   output logic               MR1,
   output logic               MR2,
   output logic [3:0]         Q,
   output logic [3:0]         Qbar
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRESET = 2'd1,
      RUN    = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [BURST_W-1:0] REM_ZERO = {BURST_W{1'b0}};
   localparam logic [BURST_W-1:0] REM_ONE  = BURST_W'(1'b1);

   state_t             state_r;
   logic [3:0]         q_r;
   logic [3:0]         qbar_r;
   logic [BURST_W-1:0] rem_r;
   logic               gnt_even_r;
   logic               gnt_odd_r;
   logic               done_r;
   logic               ms_r;
   logic               mr_r;
   logic               last_odd_r;   // 1: odd was served most recently
   logic               sel_odd_r;    // client currently being served

   logic               pick_even_s;
   logic               pick_odd_s;
   logic               hold_s;
   logic               run_step_s;

   // BCD step by two: 8 wraps to 0 and 9 wraps to 1.
   function automatic logic [3:0] bcd_add2(input logic [3:0] v);
      logic [3:0] r;
      if (v >= 4'd8) begin
         r = v - 4'd8;
      end else begin
         r = v + 4'd2;
      end
      return r;
   endfunction

   // Round-robin pick: on a tie the client not served last wins.
   assign pick_even_s = req_even & (~req_odd | last_odd_r);
   assign pick_odd_s  = req_odd  & (~req_even | ~last_odd_r);

   // The granted client keeps its request high for the burst to continue.
   assign hold_s = sel_odd_r ? req_odd : req_even;

`ifdef BCD_SCHED_PAUSE_EN
   assign run_step_s = ~pause;
`else
   assign run_step_s = 1'b1;
`endif

   // Scheduler FSM with all outputs and the shared counter registered.
   always_ff @(posedge Clk) begin
      if (rst) begin
         state_r    <= IDLE;
         q_r        <= 4'd0;
         qbar_r     <= 4'hF;
         rem_r      <= REM_ZERO;
         gnt_even_r <= 1'b0;
         gnt_odd_r  <= 1'b0;
         done_r     <= 1'b0;
         ms_r       <= 1'b0;
         mr_r       <= 1'b0;
         last_odd_r <= 1'b1;
         sel_odd_r  <= 1'b0;
      end else begin
         // strobes and done are single-cycle unless a branch re-asserts them
         ms_r   <= 1'b0;
         mr_r   <= 1'b0;
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (pick_even_s) begin
                  state_r    <= PRESET;
                  sel_odd_r  <= 1'b0;
                  rem_r      <= len_even;
                  gnt_even_r <= 1'b1;
                  mr_r       <= 1'b1;
               end else if (pick_odd_s) begin
                  state_r    <= PRESET;
                  sel_odd_r  <= 1'b1;
                  rem_r      <= len_odd;
                  gnt_odd_r  <= 1'b1;
                  ms_r       <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end
            PRESET: begin
               if (!hold_s) begin
                  // abort: count keeps its previous value
                  state_r    <= IDLE;
                  gnt_even_r <= 1'b0;
                  gnt_odd_r  <= 1'b0;
                  last_odd_r <= sel_odd_r;
               end else begin
                  q_r    <= sel_odd_r ? 4'd9 : 4'd0;
                  qbar_r <= sel_odd_r ? 4'd6 : 4'hF;
                  // zero-length burst goes to DONE; done follows one edge later
                  state_r <= (rem_r == REM_ZERO) ? DONE : RUN;
               end
            end
            RUN: begin
               if (!hold_s) begin
                  state_r    <= IDLE;
                  gnt_even_r <= 1'b0;
                  gnt_odd_r  <= 1'b0;
                  last_odd_r <= sel_odd_r;
               end else if (run_step_s) begin
                  q_r    <= bcd_add2(q_r);
                  qbar_r <= ~bcd_add2(q_r);
                  rem_r  <= rem_r - REM_ONE;
                  if (rem_r == REM_ONE) begin
                     state_r <= DONE;
                     done_r  <= 1'b1;
                  end else begin
                     state_r <= RUN;
                  end
               end else begin
                  state_r <= RUN;
               end
            end
            DONE: begin
               if (!done_r) begin
                  // entered from a zero-length preset: pulse done now
                  state_r <= DONE;
                  done_r  <= 1'b1;
               end else begin
                  state_r    <= IDLE;
                  gnt_even_r <= 1'b0;
                  gnt_odd_r  <= 1'b0;
                  last_odd_r <= sel_odd_r;
               end
            end
            default: begin
               state_r    <= IDLE;
               gnt_even_r <= 1'b0;
               gnt_odd_r  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt_even = gnt_even_r;
   assign gnt_odd  = gnt_odd_r;
   assign done     = done_r;
   assign MS1      = ms_r;
   assign MS2      = ms_r;
   assign MR1      = mr_r;
   assign MR2      = mr_r;
   assign Q        = q_r;
   assign Qbar     = qbar_r;

endmodule

// File: tb/tb_bcd_eo_scheduler.sv
// Testbench for bcd_eo_scheduler: a vector table for reset and two full
// bursts, hand-written sequences for tie/fairness, abort, zero length and
// reset mid-burst, then random traffic against a burst-level model.

module tb_bcd_eo_scheduler;

   logic       Clk = 1'b0;
   logic       rst;
   logic       req_even, req_odd;
   logic [3:0] len_even, len_odd;
   logic       gnt_even, gnt_odd, done, MS1, MS2, MR1, MR2;
   logic [3:0] Q, Qbar;

   int n_checks = 0;
   int n_errors = 0;

   bcd_eo_scheduler #(.BURST_W(4)) dut (
      .Clk(Clk), .rst(rst), .req_even(req_even), .req_odd(req_odd),
      .len_even(len_even), .len_odd(len_odd),
      .gnt_even(gnt_even), .gnt_odd(gnt_odd), .done(done),
      .MS1(MS1), .MS2(MS2), .MR1(MR1), .MR2(MR2), .Q(Q), .Qbar(Qbar)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic       r, re, ro;
      logic [3:0] le, lo;
      logic       ge, go, dn, ms, mr;
      logic [3:0] q;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, re, ro, input logic [3:0] le, lo,
                      input logic ge, go, dn, ms, mr, input logic [3:0] q);
      vec_t v;
      v.r = r; v.re = re; v.ro = ro; v.le = le; v.lo = lo;
      v.ge = ge; v.go = go; v.dn = dn; v.ms = ms; v.mr = mr; v.q = q;
      tbl.push_back(v);
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input logic r, re, ro, input logic [3:0] le, lo);
      rst = r; req_even = re; req_odd = ro; len_even = le; len_odd = lo;
   endtask

   // Compare every output at once; Qbar is expected as the complement of Q.
   task automatic chk_out(input string name, input logic ge, go, dn, ms, mr,
                          input logic [3:0] q);
      logic [14:0] act, exp_v;
      act   = {gnt_even, gnt_odd, done, MS1, MS2, MR1, MR2, Q, Qbar};
      exp_v = {ge, go, dn, ms, ms, mr, mr, q, ~q};
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got {ge,go,dn,ms1,ms2,mr1,mr2,q,qbar}=%b expected %b",
                  name, act, exp_v);
      end
   endtask

   // Burst-level reference: tracks owner, cycles since grant and length;
   // the count is a closed-form function of the elapsed steps.
   bit m_busy, m_who, m_last;
   int m_t, m_len, m_q;

   task automatic model_edge(input bit r, re, ro, input int le, lo);
      int total, pre, steps;
      if (r) begin
         m_busy = 1'b0; m_q = 0; m_last = 1'b1;
      end else if (!m_busy) begin
         if (re && (!ro || m_last)) begin
            m_busy = 1'b1; m_who = 1'b0; m_t = 0; m_len = le;
         end else if (ro) begin
            m_busy = 1'b1; m_who = 1'b1; m_t = 0; m_len = lo;
         end
      end else begin
         total = (m_len == 0) ? 3 : m_len + 2;
         pre   = m_who ? 9 : 0;
         if (m_t <= m_len && !(m_who ? ro : re)) begin
            m_busy = 1'b0; m_last = m_who;
         end else begin
            m_t++;
            steps = (m_t - 1 < m_len) ? m_t - 1 : m_len;
            m_q = (pre + 2 * steps) % 10;
            if (m_t == total) begin
               m_busy = 1'b0; m_last = m_who;
            end
         end
      end
   endtask

   initial begin
      int total;
      logic [3:0] mq;
      logic re_r, ro_r, rr;
      logic [3:0] le_r, lo_r;

      drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);

      // reset, even burst len 3 (len changed mid-burst), odd burst len 6
      add(1,0,0,4'd0,4'd0, 0,0,0,0,0,4'd0);
      add(1,0,0,4'd0,4'd0, 0,0,0,0,0,4'd0);
      add(0,1,0,4'd3,4'd0, 1,0,0,0,1,4'd0);
      add(0,1,0,4'd3,4'd0, 1,0,0,0,0,4'd0);
      add(0,1,0,4'd9,4'd0, 1,0,0,0,0,4'd2);
      add(0,1,0,4'd9,4'd0, 1,0,0,0,0,4'd4);
      add(0,1,0,4'd9,4'd0, 1,0,1,0,0,4'd6);
      add(0,0,0,4'd9,4'd0, 0,0,0,0,0,4'd6);
      add(0,0,1,4'd0,4'd6, 0,1,0,1,0,4'd6);
      add(0,0,1,4'd0,4'd6, 0,1,0,0,0,4'd9);
      add(0,0,1,4'd0,4'd2, 0,1,0,0,0,4'd1);
      add(0,0,1,4'd0,4'd2, 0,1,0,0,0,4'd3);
      add(0,0,1,4'd0,4'd2, 0,1,0,0,0,4'd5);
      add(0,0,1,4'd0,4'd2, 0,1,0,0,0,4'd7);
      add(0,0,1,4'd0,4'd2, 0,1,0,0,0,4'd9);
      add(0,0,1,4'd0,4'd2, 0,1,1,0,0,4'd1);
      add(0,0,0,4'd0,4'd0, 0,0,0,0,0,4'd1);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].r, tbl[i].re, tbl[i].ro, tbl[i].le, tbl[i].lo);
         tick();
         chk_out($sformatf("table_row%0d", i), tbl[i].ge, tbl[i].go,
                 tbl[i].dn, tbl[i].ms, tbl[i].mr, tbl[i].q);
      end

      // tie from reset: even first, then odd, then even again
      drive(1, 0, 0, 4'd0, 4'd0); tick();
      drive(0, 1, 1, 4'd1, 4'd1);
      tick(); chk_out("tie_grant_even", 1,0,0,0,1,4'd0);
      tick(); chk_out("tie_even_preset", 1,0,0,0,0,4'd0);
      tick(); chk_out("tie_even_done", 1,0,1,0,0,4'd2);
      req_even = 1'b0;
      tick(); chk_out("tie_even_release", 0,0,0,0,0,4'd2);
      tick(); chk_out("tie_grant_odd", 0,1,0,1,0,4'd2);
      tick(); chk_out("tie_odd_preset", 0,1,0,0,0,4'd9);
      tick(); chk_out("tie_odd_done", 0,1,1,0,0,4'd1);
      req_even = 1'b1;
      tick(); chk_out("tie_odd_release", 0,0,0,0,0,4'd1);
      tick(); chk_out("tie_regrant_even", 1,0,0,0,1,4'd1);
      tick(); chk_out("tie2_preset", 1,0,0,0,0,4'd0);
      tick(); chk_out("tie2_done", 1,0,1,0,0,4'd2);
      drive(0, 0, 0, 4'd0, 4'd0);
      tick(); chk_out("tie2_release", 0,0,0,0,0,4'd2);

      // abort odd len 5 after two steps, pending even with len 0 then served
      drive(0, 0, 1, 4'd0, 4'd5);
      tick(); chk_out("abort_grant", 0,1,0,1,0,4'd2);
      tick(); chk_out("abort_preset", 0,1,0,0,0,4'd9);
      tick(); chk_out("abort_step1", 0,1,0,0,0,4'd1);
      tick(); chk_out("abort_step2", 0,1,0,0,0,4'd3);
      drive(0, 1, 0, 4'd0, 4'd5);
      tick(); chk_out("abort_release", 0,0,0,0,0,4'd3);
      tick(); chk_out("len0_grant", 1,0,0,0,1,4'd3);
      tick(); chk_out("len0_preset", 1,0,0,0,0,4'd0);
      tick(); chk_out("len0_done", 1,0,1,0,0,4'd0);
      req_even = 1'b0;
      tick(); chk_out("len0_release", 0,0,0,0,0,4'd0);

      // reset in the middle of RUN
      drive(0, 0, 1, 4'd0, 4'd7);
      tick(); chk_out("rstrun_grant", 0,1,0,1,0,4'd0);
      tick(); chk_out("rstrun_preset", 0,1,0,0,0,4'd9);
      tick(); chk_out("rstrun_step", 0,1,0,0,0,4'd1);
      rst = 1'b1;
      tick(); chk_out("rstrun_reset", 0,0,0,0,0,4'd0);
      drive(0, 0, 0, 4'd0, 4'd0);
      tick(); chk_out("rstrun_idle", 0,0,0,0,0,4'd0);

      // random traffic against the model
      drive(1, 0, 0, 4'd0, 4'd0); tick();
      model_edge(1'b1, 1'b0, 1'b0, 0, 0);
      re_r = 1'b0; ro_r = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         rr = ($urandom_range(0, 299) == 0);
         if (re_r) re_r = ($urandom_range(0, 19) != 0);
         else      re_r = ($urandom_range(0, 2) == 0);
         if (ro_r) ro_r = ($urandom_range(0, 19) != 0);
         else      ro_r = ($urandom_range(0, 2) == 0);
         le_r = 4'($urandom_range(0, 15));
         lo_r = 4'($urandom_range(0, 15));
         drive(rr, re_r, ro_r, le_r, lo_r);
         tick();
         model_edge(rr, re_r, ro_r, int'(le_r), int'(lo_r));
         total = (m_len == 0) ? 3 : m_len + 2;
         mq = 4'(m_q);
         chk_out($sformatf("random_cycle%0d", c),
                 m_busy && !m_who, m_busy && m_who,
                 m_busy && (m_t == total - 1),
                 m_busy && (m_t == 0) && m_who,
                 m_busy && (m_t == 0) && !m_who, mq);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
